regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file (WEN/RW/busW) between two write-back requesters: A (ALU result) and B (load/memory result).
- Arbitration is round-robin with a valid/ready handshake per requester.
- Drives registered WEN/RW/busW straight into the register file, drops writes to r0, and counts committed writes for debug.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 81 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters, the arbiter and the register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              WEN;
    logic [ADDR_W-1:0] RW;
    logic [DATA_W-1:0] busW;

    // Requesters and register file as seen from outside the arbiter.
    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready, WEN, RW, busW
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready, WEN, RW, busW
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B)
// write-back, with a registered write port, r0 suppression and a saturating commit counter.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             hold,
    regfile_wb_arbiter_if.slave bus,
    output logic             last_grant,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

    grant_e            last_q, last_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] busw_q, busw_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              prio_a;
    logic              a_rdy, b_rdy;

    always_comb begin
        prio_a = (last_q == GNT_B);
        // Reset is folded in so neither side sees a handshake while the arbiter is held in reset.
        a_rdy  = Reset & ~hold & bus.a_valid & (~bus.b_valid | prio_a);
        b_rdy  = Reset & ~hold & bus.b_valid & (~bus.a_valid | ~prio_a);

        last_d = last_q;
        wen_d  = 1'b0;
        rw_d   = rw_q;
        busw_d = busw_q;
        if (a_rdy) begin
            rw_d   = bus.a_rd;
            busw_d = bus.a_data;
            wen_d  = (bus.a_rd != '0);
            last_d = GNT_A;
        end else if (b_rdy) begin
            rw_d   = bus.b_rd;
            busw_d = bus.b_data;
            wen_d  = (bus.b_rd != '0);
            last_d = GNT_B;
        end

        cnt_d = cnt_q;
        if (wen_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            last_q <= GNT_B;
            wen_q  <= 1'b0;
            rw_q   <= '0;
            busw_q <= '0;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            wen_q  <= wen_d;
            rw_q   <= rw_d;
            busw_q <= busw_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.a_ready = a_rdy;
    assign bus.b_ready = b_rdy;
    assign bus.WEN     = wen_q;
    assign bus.RW      = rw_q;
    assign bus.busW    = busw_q;
    assign last_grant  = last_q;
    assign wr_count    = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of regfile_wb_arbiter against a cycle-level grant/commit model.
module tb_regfile_wb_arbiter;

    logic        Clk;
    logic        Reset;
    logic        hold;
    logic        last_grant;
    logic [15:0] wr_count;
    logic        last_grant_s;
    logic [1:0]  wr_count_s;

    int unsigned checks = 0;
    int unsigned errors = 0;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus_s ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .hold       (hold),
        .bus        (bus.slave),
        .last_grant (last_grant),
        .wr_count   (wr_count)
    );

    // Narrow counter instance so saturation is reachable in a few cycles.
    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut_s (
        .Clk        (Clk),
        .Reset      (Reset),
        .hold       (hold),
        .bus        (bus_s.slave),
        .last_grant (last_grant_s),
        .wr_count   (wr_count_s)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file fed by the DUT write port.
    logic [31:0] rf [32];
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (bus.WEN) begin
            rf[bus.RW] <= bus.busW;
        end
    end

    // Reference model state.
    bit          m_prio_a;
    bit          m_wen;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;
    int unsigned m_cnt;
    logic [31:0] exp_rf [32];
    bit          acc_a, acc_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prio_a = 1'b1;
        m_wen    = 1'b0;
        m_rw     = '0;
        m_busw   = '0;
        m_cnt    = 0;
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".WEN"}, bus.WEN, 1'b0);
        check({tag, ".RW"}, bus.RW, 5'd0);
        check({tag, ".busW"}, bus.busW, 32'd0);
        check({tag, ".last_grant"}, last_grant, 1'b1);
        check({tag, ".wr_count"}, wr_count, 16'd0);
        check({tag, ".a_ready"}, bus.a_ready, 1'b0);
        check({tag, ".b_ready"}, bus.b_ready, 1'b0);
    endtask

    // One cycle: called just after a falling edge with inputs already applied.
    task automatic step(input string tag);
        bit ea, eb;
        #1;
        ea = 0;
        eb = 0;
        if (!hold) begin
            if (bus.a_valid && bus.b_valid) begin
                ea = m_prio_a;
                eb = !m_prio_a;
            end else begin
                ea = bus.a_valid;
                eb = bus.b_valid;
            end
        end
        check({tag, ".a_ready"}, bus.a_ready, ea);
        check({tag, ".b_ready"}, bus.b_ready, eb);
        m_wen = 1'b0;
        if (ea) begin
            m_rw = bus.a_rd; m_busw = bus.a_data; m_wen = (bus.a_rd != 0); m_prio_a = 1'b0;
        end else if (eb) begin
            m_rw = bus.b_rd; m_busw = bus.b_data; m_wen = (bus.b_rd != 0); m_prio_a = 1'b1;
        end
        if (m_wen) begin
            if (m_cnt < 65535) m_cnt++;
            exp_rf[m_rw] = m_busw;
        end
        acc_a = ea;
        acc_b = eb;
        @(posedge Clk);
        #1;
        check({tag, ".WEN"}, bus.WEN, m_wen);
        check({tag, ".RW"}, bus.RW, m_rw);
        check({tag, ".busW"}, bus.busW, m_busw);
        check({tag, ".last_grant"}, last_grant, m_prio_a);
        check({tag, ".wr_count"}, wr_count, m_cnt[15:0]);
        @(negedge Clk);
    endtask

    task automatic set_a(input bit v, input logic [4:0] rd, input logic [31:0] d);
        bus.a_valid = v; bus.a_rd = rd; bus.a_data = d;
    endtask

    task automatic set_b(input bit v, input logic [4:0] rd, input logic [31:0] d);
        bus.b_valid = v; bus.b_rd = rd; bus.b_data = d;
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b0;
        #1;
        check_reset_state(tag);
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
    endtask

    initial begin
        Reset = 1'b1;
        hold  = 1'b0;
        set_a(0, '0, '0);
        set_b(0, '0, '0);
        bus_s.a_valid = 0; bus_s.a_rd = '0; bus_s.a_data = '0;
        bus_s.b_valid = 0; bus_s.b_rd = '0; bus_s.b_data = '0;
        model_reset();
        #1;
        Reset = 1'b0;
        set_a(1, 5'd4, 32'h55);
        #1;
        check_reset_state("por");
        set_a(0, '0, '0);
        @(negedge Clk);
        Reset = 1'b1;

        // A alone
        set_a(1, 5'd3, 32'h1234);
        step("a_only");
        check("a_only.count1", wr_count, 16'd1);
        set_a(0, '0, '0);
        step("idle0");

        // Both valid from reset: A, B, A, B
        do_reset("rst1");
        set_a(1, 5'd5, 32'h5005);
        set_b(1, 5'd6, 32'h6006);
        for (int i = 0; i < 4; i++) begin
            step("fair");
            check("fair.RW", bus.RW, (i % 2 == 0) ? 5'd5 : 5'd6);
        end
        check("fair.count4", wr_count, 16'd4);

        // Same-rd collision, last_grant=1 here
        set_a(1, 5'd7, 32'hAAAA);
        set_b(1, 5'd7, 32'hBBBB);
        step("coll1");
        check("coll1.busW", bus.busW, 32'hAAAA);
        set_a(0, '0, '0);
        step("coll2");
        check("coll2.busW", bus.busW, 32'hBBBB);
        set_b(0, '0, '0);
        step("coll_idle");
        check("coll.r7", rf[7], 32'hBBBB);

        // r0 write is accepted but not committed
        set_b(1, 5'd0, 32'hFFFF_FFFF);
        step("r0");
        check("r0.WEN", bus.WEN, 1'b0);
        set_b(0, '0, '0);
        step("r0_idle");

        // hold with both valid; priority survives
        set_a(1, 5'd10, 32'hA10);
        set_b(1, 5'd11, 32'hB11);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) step("hold");
        hold = 1'b0;
        step("unhold");
        set_a(0, '0, '0);
        set_b(0, '0, '0);
        step("unhold_idle");

        // Randomized traffic with valid held until accepted
        for (int i = 0; i < 400; i++) begin
            if (!bus.a_valid || acc_a) set_a($urandom_range(0, 1), 5'($urandom), $urandom);
            if (!bus.b_valid || acc_b) set_b($urandom_range(0, 1), 5'($urandom), $urandom);
            hold = ($urandom_range(0, 9) == 0);
            step("rand");
        end
        hold = 1'b0;
        set_a(0, '0, '0);
        set_b(0, '0, '0);
        step("rand_idle");
        for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), rf[i], exp_rf[i]);

        // Reset while a write is on the output
        set_a(1, 5'd9, 32'h9999);
        step("pre_rst");
        check("pre_rst.WEN", bus.WEN, 1'b1);
        do_reset("mid_rst");
        set_a(0, '0, '0);
        step("post_rst");

        // Saturation on the 2-bit counter instance
        bus_s.a_valid = 1; bus_s.a_rd = 5'd1; bus_s.a_data = 32'h77;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            check("sat.count", wr_count_s, (i < 3) ? 2'(i + 1) : 2'd3);
            check("sat.WEN", bus_s.WEN, 1'b1);
            @(negedge Clk);
        end
        bus_s.a_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
